// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
//   Shared definitions for the Hack program loader:
//   - state_t    : loader FSM states (also exported on the debug state port)
//   - CMD_*      : command bytes accepted while idle
//   - RSP_*      : single-byte replies sent back over the uart
// ---------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        RESP    = 4'd6,
        PC_HI   = 4'd7,
        PC_LO   = 4'd8
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
    localparam logic [7:0] CMD_PC   = 8'h50;  // 'P'
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

endpackage

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   UART-driven program loader and run controller for the Hack computer.
//   Holds the CPU in reset, streams 16-bit instruction words (MSB byte first)
//   into the instruction ROM, and releases the CPU on command. It is the sole
//   owner of the CPU reset and the ROM write port.
//
//   Optional feature macro: PROG_LOADER_READBACK_EN
//     defined   : 'P' returns debug_pc as two bytes (hi, lo), sampled when 'P'
//                 is accepted.
//     undefined : 'P' is answered with NAK like any unknown byte.
//
// Parameters
//   ROM_ADDR_W      ROM address width (depth = 2**ROM_ADDR_W words)
//   TIMEOUT_CYCLES  max idle clk cycles between bytes inside a LOAD frame
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data (no backpressure)
//   tx_data    out  byte to transmit
//   tx_valid   out  tx_data valid
//   tx_ready   in   uart accepts tx_data this cycle
//   cpu_reset  out  active-high reset to the computer
//   rom_we     out  one-cycle ROM write strobe
//   rom_addr   out  ROM write address
//   rom_wdata  out  ROM write data
//   debug_pc   in   CPU program counter (readback feature only)
//   dbg_state  out  current FSM state (prog_loader_pkg::state_t encoding)
//
// Handshake: a tx byte transfers on every clk edge where tx_valid && tx_ready
// are both high; tx_valid and tx_data are held stable until that edge.
// rx has no backpressure: bytes arriving in WRITE or RESP are dropped.
// ---------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ROM_ADDR_W     = 15,
    parameter int TIMEOUT_CYCLES = 2_700_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  cpu_reset,
    output logic                  rom_we,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [15:0]           rom_wdata,
    input  logic [15:0]           debug_pc,
    output logic [3:0]            dbg_state
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_cpu_reset;
    logic                  r_rom_we;
    logic [ROM_ADDR_W-1:0] r_rom_addr;
    logic [15:0]           r_rom_wdata;
    logic [15:0]           r_words_left;  // words still to receive in this frame
    logic [ROM_ADDR_W-1:0] r_idx;         // next ROM word index, wraps naturally
    logic [7:0]            r_hi;          // latched MSB byte of current word
    logic [TMR_W-1:0]      r_timer;       // idle cycles since last rx byte

    logic w_in_frame;
    logic w_timeout;

`ifdef PROG_LOADER_READBACK_EN
    logic [7:0] r_pc_lo;
`else
    logic       w_unused_pc;
    assign w_unused_pc = ^debug_pc;
`endif

    // The timeout only guards the byte-receiving states of a LOAD frame.
    assign w_in_frame = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                        (r_state == DATA_HI) || (r_state == DATA_LO);
    // Abort on the cycle that would have been the TIMEOUT_CYCLES-th idle one.
    assign w_timeout  = w_in_frame && !rx_valid && (r_timer == TMR_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_wdata  <= 16'h0000;
            r_words_left <= 16'h0000;
            r_idx        <= '0;
            r_hi         <= 8'h00;
            r_timer      <= '0;
`ifdef PROG_LOADER_READBACK_EN
            r_pc_lo      <= 8'h00;
`endif
        end else begin
            r_rom_we <= 1'b0;

            if (w_in_frame && !rx_valid)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;

            if (w_timeout) begin
                // Partial load is kept; CPU stays held in reset.
                r_tx_data  <= RSP_NAK;
                r_tx_valid <= 1'b1;
                r_state    <= RESP;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (rx_valid) begin
                            case (rx_data)
                                CMD_LOAD: begin
                                    r_cpu_reset <= 1'b1;
                                    r_idx       <= '0;
                                    r_state     <= LEN_HI;
                                end
                                CMD_RUN: begin
                                    r_cpu_reset <= 1'b0;
                                    r_tx_data   <= RSP_ACK;
                                    r_tx_valid  <= 1'b1;
                                    r_state     <= RESP;
                                end
                                CMD_HALT: begin
                                    r_cpu_reset <= 1'b1;
                                    r_tx_data   <= RSP_ACK;
                                    r_tx_valid  <= 1'b1;
                                    r_state     <= RESP;
                                end
`ifdef PROG_LOADER_READBACK_EN
                                CMD_PC: begin
                                    r_tx_data  <= debug_pc[15:8];
                                    r_pc_lo    <= debug_pc[7:0];
                                    r_tx_valid <= 1'b1;
                                    r_state    <= PC_HI;
                                end
`endif
                                default: begin
                                    r_tx_data  <= RSP_NAK;
                                    r_tx_valid <= 1'b1;
                                    r_state    <= RESP;
                                end
                            endcase
                        end
                    end
                    LEN_HI: begin
                        if (rx_valid) begin
                            r_words_left[15:8] <= rx_data;
                            r_state            <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (rx_valid) begin
                            r_words_left[7:0] <= rx_data;
                            if ({r_words_left[15:8], rx_data} == 16'h0000) begin
                                r_tx_data  <= RSP_ACK;
                                r_tx_valid <= 1'b1;
                                r_state    <= RESP;
                            end else begin
                                r_state <= DATA_HI;
                            end
                        end
                    end
                    DATA_HI: begin
                        if (rx_valid) begin
                            r_hi    <= rx_data;
                            r_state <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        if (rx_valid) begin
                            r_rom_we    <= 1'b1;
                            r_rom_addr  <= r_idx;
                            r_rom_wdata <= {r_hi, rx_data};
                            r_state     <= WRITE;
                        end
                    end
                    WRITE: begin
                        r_idx        <= r_idx + 1'b1;
                        r_words_left <= r_words_left - 16'd1;
                        if (r_words_left == 16'd1) begin
                            r_tx_data  <= RSP_ACK;
                            r_tx_valid <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_state <= DATA_HI;
                        end
                    end
                    RESP: begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
`ifdef PROG_LOADER_READBACK_EN
                    PC_HI: begin
                        if (tx_ready) begin
                            r_tx_data <= r_pc_lo;
                            r_state   <= PC_LO;
                        end
                    end
                    PC_LO: begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
`endif
                    default: begin
                        r_tx_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign cpu_reset = r_cpu_reset;
    assign rom_we    = r_rom_we;
    assign rom_addr  = r_rom_addr;
    assign rom_wdata = r_rom_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader. Small ROM (8 words) and a short timeout
//   keep runtime low while still reaching the wrap and timeout boundaries.
// ---------------------------------------------------------------------------
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW  = 3;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          cpu_reset;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic [15:0]   debug_pc = 16'h0000;
  logic [3:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [AW+15:0] wr_q[$];   // observed ROM writes {addr, data}
  logic [AW+15:0] exp_q[$];  // expected ROM writes {addr, data}

  prog_loader #(.ROM_ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_reset(cpu_reset), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .debug_pc(debug_pc), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ROM write monitor
  always @(negedge clk) begin
    if (!reset && rom_we === 1'b1) wr_q.push_back({rom_addr, rom_wdata});
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] exp, input string name);
    int  cyc;
    bit  seen;
    cyc = 0;
    seen = 0;
    while (cyc < 1000 && !seen) begin
      @(negedge clk);
      if (tx_valid === 1'b1) seen = 1;
      else cyc++;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: tx_valid never rose, required byte %h", name, exp);
    end else begin
      n_cmp++;
      if (tx_data !== exp) begin
        n_err++;
        $display("FAIL %s: tx_data=%h required %h", name, tx_data, exp);
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic check_writes(input string name);
    n_cmp++;
    if (wr_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d writes required %0d", name, wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (wr_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s[%0d]: got addr %0d data %h required addr %0d data %h", name, i,
                   wr_q[i][AW+15:16], wr_q[i][15:0], exp_q[i][AW+15:16], exp_q[i][15:0]);
        end
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++;
    if (tx_data !== 8'h00 || rom_addr !== '0 || rom_wdata !== 16'h0000 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_vals: tx_data=%h rom_addr=%0d rom_wdata=%h state=%0d required 0/0/0/0",
               tx_data, rom_addr, rom_wdata, dbg_state);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_reset !== 1'b1 || tx_valid !== 1'b0 || rom_we !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: cpu_reset=%b tx_valid=%b rom_we=%b required 1/0/0",
                 i, cpu_reset, tx_valid, rom_we);
      end
    end
  endtask

  task automatic test_load();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({3'd0, 16'h1234});
    exp_q.push_back({3'd1, 16'hABCD});
    send_byte(CMD_LOAD);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    // one cycle after the LO byte's rx_valid the strobe must be up
    n_cmp++;
    if (rom_we !== 1'b1 || rom_addr !== 3'd1 || rom_wdata !== 16'hABCD) begin
      n_err++;
      $display("FAIL load_latency: rom_we=%b addr=%0d data=%h required 1/1/abcd",
               rom_we, rom_addr, rom_wdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rom_we !== 1'b0) begin
      n_err++;
      $display("FAIL load_we_width: rom_we=%b required 0", rom_we);
    end
    expect_tx(RSP_ACK, "load_ack");
    check_writes("load_writes");
  endtask

  task automatic test_run_halt();
    send_byte(CMD_RUN);
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_err++;
      $display("FAIL run_cpu_reset: cpu_reset=%b required 0", cpu_reset);
    end
    expect_tx(RSP_ACK, "run_ack");
    send_byte(8'h7A);
    expect_tx(RSP_NAK, "unknown_nak");
    n_cmp++;
    if (cpu_reset !== 1'b0) begin
      n_err++;
      $display("FAIL unknown_cpu_reset: cpu_reset=%b required 0", cpu_reset);
    end
    send_byte(CMD_HALT);
    n_cmp++;
    if (cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL halt_cpu_reset: cpu_reset=%b required 1", cpu_reset);
    end
    expect_tx(RSP_ACK, "halt_ack");
  endtask

  task automatic test_timeout();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({3'd0, 16'h0001});
    send_byte(CMD_LOAD);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h01);
    repeat (150) @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: tx_valid=%b required 0", tx_valid);
    end
    expect_tx(RSP_NAK, "timeout_nak");
    check_writes("timeout_writes");
    n_cmp++;
    if (cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_cpu_reset: cpu_reset=%b required 1", cpu_reset);
    end
  endtask

  task automatic test_zero_len_backpressure();
    wr_q.delete(); exp_q.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== RSP_ACK) begin
        n_err++;
        $display("FAIL zero_len_hold cyc %0d: tx_valid=%b tx_data=%h required 1/06",
                 i, tx_valid, tx_data);
      end
    end
    expect_tx(RSP_ACK, "zero_len_ack");
    check_writes("zero_len_writes");
  endtask

  task automatic test_wrap();
    wr_q.delete(); exp_q.delete();
    send_byte(CMD_RUN);
    expect_tx(RSP_ACK, "wrap_run_ack");
    send_byte(CMD_LOAD);
    n_cmp++;
    if (cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL load_cpu_reset: cpu_reset=%b required 1", cpu_reset);
    end
    send_byte(8'h00); send_byte(8'h09);
    for (int i = 0; i < 9; i++) begin
      logic [15:0] w;
      logic [AW-1:0] a;
      w = 16'h1000 + 16'(i);
      a = AW'(i % 8);
      exp_q.push_back({a, w});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    expect_tx(RSP_ACK, "wrap_ack");
    check_writes("wrap_writes");
  endtask

  task automatic test_async_reset();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({3'd0, 16'h1122});
    exp_q.push_back({3'd0, 16'h55AA});
    send_byte(CMD_LOAD);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cpu_reset !== 1'b1 || rom_we !== 1'b0 || tx_valid !== 1'b0 || rom_addr !== '0 ||
        rom_wdata !== 16'h0000 || tx_data !== 8'h00 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL async_reset: cpu_reset=%b rom_we=%b tx_valid=%b addr=%0d wdata=%h tx=%h st=%0d",
               cpu_reset, rom_we, tx_valid, rom_addr, rom_wdata, tx_data, dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(CMD_LOAD);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'hAA);
    expect_tx(RSP_ACK, "reload_ack");
    check_writes("async_reset_writes");
  endtask

  task automatic test_readback();
    debug_pc = 16'h0123;
    send_byte(CMD_PC);
    debug_pc = 16'hFFFF;
`ifdef PROG_LOADER_READBACK_EN
    expect_tx(8'h01, "pc_hi");
    expect_tx(8'h23, "pc_lo");
`else
    expect_tx(RSP_NAK, "pc_nak");
`endif
    @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL readback_end: tx_valid=%b state=%0d required 0/0", tx_valid, dbg_state);
    end
  endtask

  // main sequence and final report
  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_timeout();
    test_zero_len_backpressure();
    test_wrap();
    test_async_reset();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
